// File: rtl/regfile_sb_if.sv
// regfile_sb_if: bus between the core datapath and the scoreboarded register file.
//   master: datapath side (drives writeback, issue and read addresses).
//   slave : register file side (returns read data, busy flags, count, debug tap).
// Signals:
//   wr_en/wr_addr/wr_data : writeback strobe, destination, value
//   iss_en/iss_rd         : instruction issue and its destination register
//   rd_addr               : packed read addresses, port k at [k*AW +: AW]
//   rd_data/rd_busy       : packed registered read data and per-port pending flag
//   busy_cnt              : registered number of pending registers
//   dbg_data              : registered copy of the debug-tapped register
interface regfile_sb_if #(
   parameter int unsigned XLEN   = 32,
   parameter int unsigned NREGS  = 32,
   parameter int unsigned NUM_RD = 2
);
   localparam int unsigned AW = $clog2(NREGS);

   logic                   wr_en;
   logic [AW-1:0]          wr_addr;
   logic [XLEN-1:0]        wr_data;
   logic                   iss_en;
   logic [AW-1:0]          iss_rd;
   logic [NUM_RD*AW-1:0]   rd_addr;
   logic [NUM_RD*XLEN-1:0] rd_data;
   logic [NUM_RD-1:0]      rd_busy;
   logic [AW:0]            busy_cnt;
   logic [XLEN-1:0]        dbg_data;

   modport master (
      output wr_en, wr_addr, wr_data, iss_en, iss_rd, rd_addr,
      input  rd_data, rd_busy, busy_cnt, dbg_data
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, iss_en, iss_rd, rd_addr,
      output rd_data, rd_busy, busy_cnt, dbg_data
   );
endinterface

// File: rtl/regfile_sb.sv
// regfile_sb: parametrised register file with pending-write scoreboard and debug tap.
// All state updates on the falling edge of CLK, qualified by clk_cpu.
// Ports:
//   CLK     : clock, falling edge only
//   RST_N   : asynchronous active-low reset, clears storage, busy bits and outputs
//   clk_cpu : edge enable; nothing changes on edges where it is 0
//   bus     : regfile_sb_if.slave (writeback, issue, read ports, busy count, debug tap)
// Configuration macro:
//   REGFILE_BYPASS_EN : when defined, a same-edge write is forwarded to matching read
//                       ports and to dbg_data; otherwise reads return pre-edge contents.
module regfile_sb #(
   parameter int unsigned XLEN    = 32,
   parameter int unsigned NREGS   = 32,
   parameter int unsigned NUM_RD  = 2,
   parameter int unsigned DBG_REG = 1
) (
   input logic         CLK,
   input logic         RST_N,
   input logic         clk_cpu,
   regfile_sb_if.slave bus
);
   localparam int unsigned AW = $clog2(NREGS);
   localparam logic [AW-1:0] DbgAddr = AW'(DBG_REG);

   logic [XLEN-1:0]        reg_q [NREGS];
   logic [XLEN-1:0]        reg_d [NREGS];
   logic [NREGS-1:0]       busy_q, busy_d;
   logic [NUM_RD*XLEN-1:0] rd_data_q, rd_data_d;
   logic [NUM_RD-1:0]      rd_busy_q, rd_busy_d;
   logic [AW:0]            busy_cnt_q, busy_cnt_d;
   logic [XLEN-1:0]        dbg_data_q, dbg_data_d;
   logic                   wr_hit;
   logic                   iss_hit;

   // R0 is hardwired: writes and issues to it are ignored
   assign wr_hit  = bus.wr_en && (bus.wr_addr != '0);
   assign iss_hit = bus.iss_en && (bus.iss_rd != '0);

   always_comb begin
      busy_d = busy_q;
      if (wr_hit) busy_d[bus.wr_addr] = 1'b0;
      // a same-edge issue overrides the clear: a newer producer is outstanding
      if (iss_hit) busy_d[bus.iss_rd] = 1'b1;
      busy_cnt_d = '0;
      for (int unsigned i = 0; i < NREGS; i++) begin
         busy_cnt_d = busy_cnt_d + {{AW{1'b0}}, busy_d[i]};
      end
   end

   always_comb begin
      reg_d = reg_q;
      if (wr_hit) reg_d[bus.wr_addr] = bus.wr_data;
   end

   // reads see pre-edge storage, but busy after this edge's set/clear
   always_comb begin
      rd_data_d = '0;
      rd_busy_d = '0;
      for (int unsigned k = 0; k < NUM_RD; k++) begin
         rd_data_d[k*XLEN +: XLEN] = reg_q[bus.rd_addr[k*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
         if (wr_hit && (bus.wr_addr == bus.rd_addr[k*AW +: AW])) begin
            rd_data_d[k*XLEN +: XLEN] = bus.wr_data;
         end
`endif
         rd_busy_d[k] = busy_d[bus.rd_addr[k*AW +: AW]];
      end
      dbg_data_d = reg_q[DbgAddr];
`ifdef REGFILE_BYPASS_EN
      if (wr_hit && (bus.wr_addr == DbgAddr)) dbg_data_d = bus.wr_data;
`endif
   end

   always_ff @(negedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         for (int unsigned i = 0; i < NREGS; i++) reg_q[i] <= '0;
         busy_q     <= '0;
         rd_data_q  <= '0;
         rd_busy_q  <= '0;
         busy_cnt_q <= '0;
         dbg_data_q <= '0;
      end else if (clk_cpu) begin
         reg_q      <= reg_d;
         busy_q     <= busy_d;
         rd_data_q  <= rd_data_d;
         rd_busy_q  <= rd_busy_d;
         busy_cnt_q <= busy_cnt_d;
         dbg_data_q <= dbg_data_d;
      end
   end

   assign bus.rd_data  = rd_data_q;
   assign bus.rd_busy  = rd_busy_q;
   assign bus.busy_cnt = busy_cnt_q;
   assign bus.dbg_data = dbg_data_q;
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed bench for regfile_sb (32x32, two read ports, debug tap on R1).
// A behavioural model tracks registers and pending set; a compare process checks every
// output against it on each CLK rising edge, and directed literals pin the model.
module tb_regfile_sb;
`ifdef REGFILE_BYPASS_EN
   localparam bit Byp = 1'b1;
`else
   localparam bit Byp = 1'b0;
`endif

   logic CLK = 1'b0;
   logic RST_N = 1'b0;
   logic clk_cpu = 1'b0;

   int total = 0;
   int bad = 0;

   regfile_sb_if #(.XLEN(32), .NREGS(32), .NUM_RD(2)) bus ();

   regfile_sb #(.XLEN(32), .NREGS(32), .NUM_RD(2), .DBG_REG(1)) dut (
      .CLK     (CLK),
      .RST_N   (RST_N),
      .clk_cpu (clk_cpu),
      .bus     (bus)
   );

   always #5 CLK = ~CLK;

   // model state
   logic [31:0] m_reg [32];
   bit          m_busy [32];
   logic [31:0] m_rd [2];
   bit          m_rb [2];
   int          m_cnt;
   logic [31:0] m_dbg;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 32; i++) begin
         m_reg[i] = '0;
         m_busy[i] = 1'b0;
      end
      m_rd[0] = '0; m_rd[1] = '0;
      m_rb[0] = 1'b0; m_rb[1] = 1'b0;
      m_cnt = 0;
      m_dbg = '0;
   endtask

   // one enabled edge worth of register-file behaviour, from the current inputs
   task automatic model_update();
      bit nb [32];
      int wa, ir, ra;
      if (!clk_cpu) return;
      wa = int'(bus.wr_addr);
      ir = int'(bus.iss_rd);
      nb = m_busy;
      if (bus.wr_en && wa != 0) nb[wa] = 1'b0;
      if (bus.iss_en && ir != 0) nb[ir] = 1'b1;
      for (int k = 0; k < 2; k++) begin
         ra = int'(bus.rd_addr[k*5 +: 5]);
         m_rd[k] = (ra == 0) ? 32'h0 : m_reg[ra];
         if (Byp && bus.wr_en && wa != 0 && wa == ra) m_rd[k] = bus.wr_data;
         m_rb[k] = nb[ra];
      end
      m_dbg = m_reg[1];
      if (Byp && bus.wr_en && wa == 1) m_dbg = bus.wr_data;
      if (bus.wr_en && wa != 0) m_reg[wa] = bus.wr_data;
      m_busy = nb;
      m_cnt = 0;
      for (int i = 0; i < 32; i++) if (nb[i]) m_cnt++;
   endtask

   // one CLK falling edge with the given inputs; literal checks may follow at +1
   task automatic step(input bit cpu, input bit we, input logic [4:0] wa,
                       input logic [31:0] wd, input bit ie, input logic [4:0] ir,
                       input logic [4:0] ra0, input logic [4:0] ra1);
      @(posedge CLK);
      #1;
      clk_cpu     = cpu;
      bus.wr_en   = we;
      bus.wr_addr = wa;
      bus.wr_data = wd;
      bus.iss_en  = ie;
      bus.iss_rd  = ir;
      bus.rd_addr = {ra1, ra0};
      @(negedge CLK);
      model_update();
      #1;
   endtask

   always @(posedge CLK) begin
      chk("rd_data0", bus.rd_data[31:0], m_rd[0]);
      chk("rd_data1", bus.rd_data[63:32], m_rd[1]);
      chk("rd_busy0", {31'b0, bus.rd_busy[0]}, {31'b0, m_rb[0]});
      chk("rd_busy1", {31'b0, bus.rd_busy[1]}, {31'b0, m_rb[1]});
      chk("busy_cnt", {26'b0, bus.busy_cnt}, 32'(m_cnt));
      chk("dbg_data", bus.dbg_data, m_dbg);
   end

   task automatic chk_all_zero(input string nm);
      chk({nm, "_rd_data"}, bus.rd_data[31:0] | bus.rd_data[63:32], 32'h0);
      chk({nm, "_rd_busy"}, {30'b0, bus.rd_busy}, 32'h0);
      chk({nm, "_busy_cnt"}, {26'b0, bus.busy_cnt}, 32'h0);
      chk({nm, "_dbg"}, bus.dbg_data, 32'h0);
   endtask

   initial begin
      bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
      bus.iss_en = 1'b0; bus.iss_rd = '0; bus.rd_addr = '0;
      model_reset();
      #3;
      chk_all_zero("reset");
      @(posedge CLK);
      #2 RST_N = 1'b1;

      step(1, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 5, 0);
      chk("r5_data", bus.rd_data[31:0], 32'hDEADBEEF);
      chk("r5_busy", {31'b0, bus.rd_busy[0]}, 32'h0);

      step(1, 1, 0, 32'h1234, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0, 0);
      chk("r0_data", bus.rd_data[63:32], 32'h0);
      chk("r0_cnt", {26'b0, bus.busy_cnt}, 32'h0);

      step(1, 0, 0, 0, 1, 7, 0, 0);
      step(1, 0, 0, 0, 1, 9, 7, 0);
      chk("iss_cnt", {26'b0, bus.busy_cnt}, 32'd2);
      chk("iss_r7_busy", {31'b0, bus.rd_busy[0]}, 32'h1);

      step(1, 1, 7, 32'h55, 0, 0, 7, 0);
      chk("wb_cnt", {26'b0, bus.busy_cnt}, 32'd1);
      chk("wb_r7_busy", {31'b0, bus.rd_busy[0]}, 32'h0);
      chk("wb_r7_fwd", bus.rd_data[31:0], Byp ? 32'h55 : 32'h0);
      step(1, 0, 0, 0, 0, 0, 7, 0);
      chk("wb_r7_data", bus.rd_data[31:0], 32'h55);

      step(1, 1, 3, 32'hAA, 1, 3, 0, 3);
      chk("same_r3_busy", {31'b0, bus.rd_busy[1]}, 32'h1);
      chk("same_cnt", {26'b0, bus.busy_cnt}, 32'd2);
      step(1, 0, 0, 0, 0, 0, 3, 0);
      chk("same_r3_data", bus.rd_data[31:0], 32'hAA);
      chk("same_r3_busy2", {31'b0, bus.rd_busy[0]}, 32'h1);

      step(1, 1, 4, 32'h77, 0, 0, 4, 0);
      chk("r4_same_edge", bus.rd_data[31:0], Byp ? 32'h77 : 32'h0);
      step(1, 0, 0, 0, 0, 0, 4, 0);
      chk("r4_next_edge", bus.rd_data[31:0], 32'h77);

      step(1, 1, 1, 32'hCAFE, 0, 0, 0, 0);
      chk("dbg_same_edge", bus.dbg_data, Byp ? 32'hCAFE : 32'h0);
      step(1, 0, 0, 0, 0, 0, 0, 0);
      chk("dbg_next_edge", bus.dbg_data, 32'hCAFE);

      step(1, 0, 0, 0, 0, 0, 9, 9);
      chk("dual_data_eq", bus.rd_data[31:0], bus.rd_data[63:32]);
      chk("dual_busy1", {31'b0, bus.rd_busy[1]}, 32'h1);

      for (int i = 0; i < 3; i++) begin
         step(0, 1, 5'(9 + i), 32'hFFFF0000 + 32'(i), 1, 5'(12 + i), 3, 5);
      end
      chk("hold_rd0", bus.rd_data[31:0], 32'h0);
      chk("hold_busy", {30'b0, bus.rd_busy}, 32'h3);
      chk("hold_cnt", {26'b0, bus.busy_cnt}, 32'd2);
      chk("hold_dbg", bus.dbg_data, 32'hCAFE);

      step(1, 1, 9, 32'h99, 0, 0, 9, 0);
      chk("clr_r9_cnt", {26'b0, bus.busy_cnt}, 32'd1);

      // mid-run reset, asserted away from any CLK edge
      @(posedge CLK);
      #2;
      clk_cpu = 1'b0;
      RST_N = 1'b0;
      model_reset();
      #1;
      chk_all_zero("midrst");
      @(posedge CLK);
      #2 RST_N = 1'b1;

      step(1, 0, 0, 0, 0, 0, 5, 3);
      chk("post_rst_r5", bus.rd_data[31:0], 32'h0);
      chk("post_rst_busy", {30'b0, bus.rd_busy}, 32'h0);

      @(posedge CLK);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
